// File: rtl/conv1_pixel_streamer.sv
// conv1_pixel_streamer: reads an image from memory in raster order once per
// filter. Before each pass it clears the downstream line buffer, then feeds
// every pixel to that buffer exactly once.
module conv1_pixel_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int NUM_FILTERS = 6,
    parameter int ADDR_WIDTH  = $clog2(IMG_W * IMG_H)
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    input  logic                               hold,
    input  logic                               abort,
    output logic                               mem_rd_en,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic                               new_filter,
    output logic                               data_push,
    output logic [DATA_WIDTH-1:0]              data_in,
    output logic [$clog2(NUM_FILTERS):0]       filter_idx,
    output logic                               busy,
    output logic                               done
);

    localparam int FW = $clog2(NUM_FILTERS) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [FW-1:0]         LAST_FILTER = FW'(NUM_FILTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   pix_cnt, pix_cnt_d;
    logic [FW-1:0]           fidx, fidx_d;
    logic                    rd_en;
    logic                    push_q;

    // State register plus pass/pixel counters and the read-data-valid flag.
    // NOTE: only control registers exist here, so all of them take the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            pix_cnt <= '0;
            fidx    <= '0;
            push_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state   <= state_d;
            pix_cnt <= pix_cnt_d;
            fidx    <= fidx_d;
            push_q  <= rd_en;   // memory answers one cycle after the strobe
        end
    end

    // Next-state, counter updates and the read strobe; abort overrides everything.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state;
        pix_cnt_d = pix_cnt;
        fidx_d    = fidx;
        rd_en     = 1'b0;
        if (abort && (state != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        fidx_d  = '0;
                    end
                end
                S_CLEAR: begin
                    state_d   = S_STREAM;
                    pix_cnt_d = '0;
                end
                S_STREAM: begin
                    if (!hold) begin
                        rd_en = 1'b1;
                        // Counter parks on the last address so it never overruns.
                        if (pix_cnt == LAST_ADDR) state_d = S_DRAIN;
                        else                      pix_cnt_d = pix_cnt + ADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (fidx < LAST_FILTER) begin
                        fidx_d  = fidx + FW'(1);
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mem_rd_en  = rd_en;
    assign mem_addr   = pix_cnt;
    assign new_filter = (state == S_CLEAR);
    assign data_push  = push_q;
    assign data_in    = push_q ? mem_rdata : '0;
    assign filter_idx = fidx;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE) && !abort;

endmodule
